// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream loader that packs big-endian words into program RAM and holds the CPU in reset until done
// Optional trailing checksum byte enabled by PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int Psize = 4,
    parameter int Isize = 24
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             wr_en,
    output logic [Psize-1:0] wr_addr,
    output logic [Isize:0]   wr_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             error,
    output logic [Psize:0]   word_count
);

    localparam int BPW = (Isize + 8) / 8;
    localparam int W   = Isize + 1;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERR} state_t;
    localparam state_t TERM_STATE = S_CHECK;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;
    localparam state_t TERM_STATE = S_DONE;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_byte_cnt;
    logic [W-9:0]      r_shift;
    logic [Psize-1:0]  r_addr;
    logic [Psize:0]    r_word_count;
    logic              r_wr_en;
    logic [W-1:0]      r_wr_data;

    logic              w_acc;
    logic              w_word_last;
    logic              w_full;
    logic              w_start;
    logic [Psize:0]    w_cnt_pending;
    logic [W-1:0]      w_word;

    assign w_acc         = in_valid && in_ready;
    assign w_word_last   = (r_byte_cnt == CW'(BPW - 1));
    // A write may still be pending when the next word completes, so count it too
    assign w_cnt_pending = r_word_count + (Psize+1)'(r_wr_en);
    assign w_full        = (w_cnt_pending == (Psize+1)'((1 << Psize) - 1));
    assign w_word        = {r_shift, in_data};
    assign w_start       = start && (r_state != S_LOAD)
`ifdef PROG_LOADER_CHECKSUM_EN
                           && (r_state != S_CHECK)
`endif
                           ;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic [7:0] w_sum_nxt;
    assign w_sum_nxt = r_sum + in_data;
`endif

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (start) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (w_acc) begin
                    if (in_last && !w_word_last)
                        w_state_nxt = S_ERR;
                    else if (w_word_last && (in_last || w_full))
                        w_state_nxt = TERM_STATE;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHECK: if (w_acc) w_state_nxt = (w_sum_nxt == 8'h00) ? S_DONE : S_ERR;
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == S_LOAD);
`ifdef PROG_LOADER_CHECKSUM_EN
        in_ready = in_ready || (r_state == S_CHECK);
`endif
        cpu_hold = (r_state != S_DONE);
        done     = (r_state == S_DONE);
        error    = (r_state == S_ERR);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_byte_cnt   <= '0;
            r_shift      <= '0;
            r_addr       <= '0;
            r_word_count <= '0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            if (r_wr_en) begin
                r_addr       <= r_addr + Psize'(1);
                r_word_count <= r_word_count + (Psize+1)'(1);
            end
            if (w_start) begin
                r_byte_cnt   <= '0;
                r_shift      <= '0;
                r_addr       <= '0;
                r_word_count <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                r_sum        <= '0;
`endif
            end else if (w_acc && r_state == S_LOAD) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                r_sum <= w_sum_nxt;
`endif
                if (in_last && !w_word_last) begin
                    r_byte_cnt <= '0;
                end else if (w_word_last) begin
                    r_wr_en    <= 1'b1;
                    r_wr_data  <= w_word;
                    r_byte_cnt <= '0;
                end else begin
                    // Older bytes fall off the top, discarding the unused MSBs of the first byte
                    r_shift    <= (W-8)'({r_shift, in_data});
                    r_byte_cnt <= r_byte_cnt + CW'(1);
                end
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_addr;
    assign wr_data    = r_wr_data;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader
module tb_prog_loader;

    localparam int P = 4;
    localparam int I = 24;
    localparam int W = I + 1;

    logic         clk = 1'b0;
    logic         nReset;
    logic         start;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic         wr_en;
    logic [P-1:0] wr_addr;
    logic [I:0]   wr_data;
    logic         cpu_hold;
    logic         done;
    logic         error;
    logic [P:0]   word_count;

    prog_loader #(.Psize(P), .Isize(I)) dut (
        .clk(clk), .nReset(nReset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [P+W-1:0] exp_q[$];
    logic [7:0]     tb_sum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [P+W-1:0] e;
        forever begin
            @(negedge clk);
            if (nReset && wr_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e[P+W-1:W]));
                    chk("wr_data", 32'(wr_data), 32'(e[W-1:0]));
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        tb_sum   = tb_sum + d;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_word(input logic [P-1:0] a, input logic [31:0] w, input logic last, input int maxgap);
        exp_q.push_back({a, w[W-1:0]});
        send_byte(w[31:24], 1'b0, $urandom_range(0, maxgap));
        send_byte(w[23:16], 1'b0, $urandom_range(0, maxgap));
        send_byte(w[15:8],  1'b0, $urandom_range(0, maxgap));
        send_byte(w[7:0],   last, $urandom_range(0, maxgap));
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        tb_sum = 8'h00;
    endtask

    task automatic scen2();
        do_start();
        send_word(4'd0, 32'h01234567, 1'b1 ^ 1'b1, 0);
        send_word(4'd1, 32'h00AABBCC, 1'b1, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'(8'h00 - tb_sum), 1'b0, 0);
`endif
        repeat (2) @(negedge clk);
        chk("s2_done",       32'(done),        32'd1);
        chk("s2_error",      32'(error),       32'd0);
        chk("s2_word_count", 32'(word_count),  32'd2);
        chk("s2_cpu_hold",   32'(cpu_hold),    32'd0);
        chk("s2_in_ready",   32'(in_ready),    32'd0);
        chk("s2_pending",    32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},   32'(in_ready),   32'd0);
        chk({tag, "_wr_en"},      32'(wr_en),      32'd0);
        chk({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
        chk({tag, "_wr_data"},    32'(wr_data),    32'd0);
        chk({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_error"},      32'(error),      32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    initial begin
        nReset = 1'b0; start = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
        tb_sum = 8'h00;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        nReset = 1'b1;

        // Idle after reset: nothing moves without start, even with valid data offered
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        chk_reset_vals("s1");

        scen2();

        // Early in_last aborts without writing, then a fresh load works
        do_start();
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b1, 0);
        @(negedge clk);
        chk("s3_error",    32'(error),    32'd1);
        chk("s3_done",     32'(done),     32'd0);
        chk("s3_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("s3_in_ready", 32'(in_ready), 32'd0);
        scen2();

        // Full memory without in_last, random gaps
        do_start();
        for (int i = 0; i < 16; i++)
            send_word(4'(i), 32'h9E3779B9 * 32'(i + 1), 1'b0, 2);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'(8'h00 - tb_sum), 1'b0, 0);
`endif
        repeat (2) @(negedge clk);
        chk("s4_done",       32'(done),        32'd1);
        chk("s4_word_count", 32'(word_count),  32'd16);
        chk("s4_in_ready",   32'(in_ready),    32'd0);
        chk("s4_wr_addr",    32'(wr_addr),     32'd0);
        chk("s4_pending",    32'(exp_q.size()), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        chk("s4_word_count_hold", 32'(word_count), 32'd16);

        // Asynchronous reset in the middle of the second word
        do_start();
        send_word(4'd0, 32'hDEADBEEF, 1'b0, 0);
        send_byte(8'h55, 1'b0, 0);
        #2 nReset = 1'b0;
        #1 chk_reset_vals("s5");
        repeat (3) @(negedge clk);
        chk("s5_wr_en_held", 32'(wr_en), 32'd0);
        nReset = 1'b1;
        @(negedge clk);
        scen2();

`ifdef PROG_LOADER_CHECKSUM_EN
        // Wrong checksum byte
        do_start();
        send_word(4'd0, 32'h01234567, 1'b0, 0);
        send_word(4'd1, 32'h00AABBCC, 1'b1, 0);
        send_byte(8'h00, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("s6_error",    32'(error),    32'd1);
        chk("s6_cpu_hold", 32'(cpu_hold), 32'd1);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
